// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet frame controller: FSM state
// encoding, error codes, default sync marker and the timeout helper.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TYPE    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    OUT     = 3'd5
  } state_e;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_OVR     = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Inter-byte gap limit expressed in clock cycles.
  function automatic int timeout_cycles(input int clk_freq, input int us);
    return clk_freq / 1_000_000 * us;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts cycles while enabled, restarts on clear and
// flags the last cycle of the allowed gap.
module uart_gap_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign expired = enable && (cnt_q == LAST);

  // Count the gap; clear wins, and the count parks on the last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_packet_ctrl.sv
// Frame controller behind the UART byte receiver.
// Parses SYNC, TYPE, LEN, LEN payload bytes and (with PKT_CHECKSUM_EN
// defined) a trailing XOR checksum byte, then offers the packet as one
// command.
// Command handshake: cmd_valid rises with the command fields stable and
// stays high, fields unchanged, until the cycle cmd_valid && cmd_ready;
// the controller is back in IDLE on the following cycle.
// dbg_state exposes the FSM state register for observation.
module uart_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          TIMEOUT_US = 2000,
  parameter int          MAX_LEN    = 8,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           cmd_type,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int         TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_US);
  localparam logic [7:0] MAX_LEN_B      = 8'(MAX_LEN);

`ifdef PKT_CHECKSUM_EN
  localparam state_e FINAL_ST = CHECK;
`else
  localparam state_e FINAL_ST = OUT;
`endif

  state_e               state_q, state_d;
  logic [7:0]           type_q, type_d;
  logic [3:0]           len_q, len_d;
  logic [3:0]           idx_q, idx_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [1:0]           err_code_q, err_code_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]           acc_q, acc_d;
`endif

  logic gap_active;
  logic gap_clear;
  logic gap_expired;

  // The gap timer only runs while a frame is being collected.
  assign gap_active = (state_q == TYPE) || (state_q == LEN) ||
                      (state_q == PAYLOAD) || (state_q == CHECK);
  assign gap_clear  = rx_valid || !gap_active;

  uart_gap_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (gap_clear),
    .enable  (gap_active),
    .expired (gap_expired)
  );

  // Next-state and output decode for the frame parser.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    len_d       = len_q;
    idx_d       = idx_q;
    payload_d   = payload_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef PKT_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = TYPE;
      end
      TYPE: begin
        if (rx_valid) begin
          type_d  = rx_data;
`ifdef PKT_CHECKSUM_EN
          acc_d   = rx_data;
`endif
          state_d = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          if (rx_data > MAX_LEN_B) begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            len_d     = rx_data[3:0];
            payload_d = '0;
            idx_d     = 4'd0;
`ifdef PKT_CHECKSUM_EN
            acc_d     = acc_q ^ rx_data;
`endif
            state_d   = (rx_data == 8'd0) ? FINAL_ST : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) payload_d[8*i +: 8] = rx_data;
          end
`ifdef PKT_CHECKSUM_EN
          acc_d = acc_q ^ rx_data;
`endif
          idx_d = idx_q + 4'd1;
          if (idx_q == (len_q - 4'd1)) state_d = FINAL_ST;
        end
      end
`ifdef PKT_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == acc_q) begin
            state_d = OUT;
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
      end
`endif
      OUT: begin
        // A byte arriving while the command is pending has nowhere to go.
        if (rx_valid) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; an arriving byte always takes priority.
    if (gap_active && !rx_valid && gap_expired) begin
      state_d     = IDLE;
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end

    valid_d = (state_d == OUT);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      type_q      <= 8'd0;
      len_q       <= 4'd0;
      idx_q       <= 4'd0;
      payload_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef PKT_CHECKSUM_EN
      acc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      payload_q   <= payload_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef PKT_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign cmd_type    = type_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign cmd_valid   = valid_q;
  assign busy        = busy_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;

endmodule
